// File: rtl/offnariscv_pkg.sv
// rtl/offnariscv_pkg.sv - shared states and requester constants for the memory read arbiter
package offnariscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int   ARB_NUM_REQ = 2;
    localparam logic ARB_REQ_IFU = 1'b0;
    localparam logic ARB_REQ_LSU = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way pick, round-robin or LSU-priority on contention
module rr_arbiter2
    import offnariscv_pkg::*;
(
    input  logic [ARB_NUM_REQ-1:0] req,
    input  logic                   last_grant,
    input  logic                   rr_en,
    output logic                   grant
);

    always_comb begin
        grant = ARB_REQ_IFU;
        if (req == 2'b11) begin
            grant = rr_en ? ~last_grant : ARB_REQ_LSU;
        end else if (req[ARB_REQ_LSU]) begin
            grant = ARB_REQ_LSU;
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - IFU/LSU read-path arbiter, one transaction in flight; MEM_RD_ARB_ROUND_ROBIN_EN selects round-robin
module mem_rd_arbiter
    import offnariscv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 256,
    parameter int RRESP_WIDTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ARB_NUM_REQ-1:0]                 s_arvalid,
    output logic [ARB_NUM_REQ-1:0]                 s_arready,
    input  logic [ARB_NUM_REQ-1:0][ADDR_WIDTH-1:0] s_araddr,
    input  logic [ARB_NUM_REQ-1:0][7:0]            s_arlen,
    input  logic [ARB_NUM_REQ-1:0][2:0]            s_arsize,
    output logic [ARB_NUM_REQ-1:0]                 s_rvalid,
    input  logic [ARB_NUM_REQ-1:0]                 s_rready,
    output logic [DATA_WIDTH-1:0]                  s_rdata,
    output logic [RRESP_WIDTH-1:0]                 s_rresp,
    output logic                                   s_rlast,
    input  logic [ARB_NUM_REQ-1:0]                 s_rack,
    output logic                                   m_arvalid,
    input  logic                                   m_arready,
    output logic [ADDR_WIDTH-1:0]                  m_araddr,
    output logic [7:0]                             m_arlen,
    output logic [2:0]                             m_arsize,
    input  logic                                   m_rvalid,
    output logic                                   m_rready,
    input  logic [DATA_WIDTH-1:0]                  m_rdata,
    input  logic [RRESP_WIDTH-1:0]                 m_rresp,
    input  logic                                   m_rlast,
    output logic                                   m_rack,
    output logic                                   busy
);

`ifdef MEM_RD_ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_e state;
    logic       grant_q;
    logic       last_grant_q;
    logic       pick;

    rr_arbiter2 u_pick (
        .req        (s_arvalid),
        .last_grant (last_grant_q),
        .rr_en      (RR_EN),
        .grant      (pick)
    );

    // Grant is held from AR issue through the rlast handshake, so R needs no ID routing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant_q      <= ARB_REQ_IFU;
            last_grant_q <= ARB_REQ_LSU;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_arvalid) begin
                        grant_q <= pick;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arvalid[grant_q] && m_arready) begin
                        last_grant_q <= grant_q;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (m_rvalid && s_rready[grant_q] && m_rlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_rack    = 1'b0;
        m_araddr  = s_araddr[grant_q];
        m_arlen   = s_arlen[grant_q];
        m_arsize  = s_arsize[grant_q];
        s_rdata   = m_rdata;
        s_rresp   = m_rresp;
        s_rlast   = m_rlast;
        busy      = (state != IDLE);
        case (state)
            ADDR: begin
                m_arvalid          = s_arvalid[grant_q];
                s_arready[grant_q] = m_arready;
            end
            DATA: begin
                s_rvalid[grant_q] = m_rvalid;
                m_rready          = s_rready[grant_q];
                m_rack            = s_rack[grant_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb/tb_mem_rd_arbiter.sv - vector table, corner sequences and random scoreboard for mem_rd_arbiter
module tb_mem_rd_arbiter;

`ifdef MEM_RD_ARB_ROUND_ROBIN_EN
    localparam int RR = 1;
`else
    localparam int RR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       s_arvalid, s_arready, s_rvalid, s_rready, s_rack;
    logic [1:0][31:0] s_araddr;
    logic [1:0][7:0]  s_arlen;
    logic [1:0][2:0]  s_arsize;
    logic [255:0]     s_rdata, m_rdata;
    logic [3:0]       s_rresp, m_rresp;
    logic             s_rlast, m_rlast;
    logic             m_arvalid, m_arready, m_rvalid, m_rready, m_rack, busy;
    logic [31:0]      m_araddr;
    logic [7:0]       m_arlen;
    logic [2:0]       m_arsize;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rack(s_rack),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rack(m_rack), .busy(busy)
    );

    typedef struct {
        logic [1:0]  arv;
        logic        mar, mrv, mrl;
        logic [1:0]  srr, rack;
        logic [7:0]  exp;
        logic        chk_ar;
        logic [39:0] exp_ar;
    } vec_t;
    vec_t tab[$];

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {m_arvalid, s_arready, s_rvalid, m_rready, m_rack, busy};
    endfunction

    function automatic logic [1:0] onehot(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int pick(input logic [1:0] r, input int lg);
        if (r == 2'b11) return (RR != 0) ? 1 - lg : 1;
        return r[1] ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        s_arvalid = '0; s_rready = '0; s_rack = '0;
        m_arready = 0; m_rvalid = 0; m_rlast = 0;
        m_rdata = '0; m_rresp = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 0;
        tick();
        tick();
        check("reset_outs", outs(), 8'h00);
        rst = 1;
        tick();
    endtask

    task automatic add(input logic [1:0] arv, input logic mar, mrv, mrl, input logic [1:0] srr, rack,
                       input logic [7:0] exp, input logic chk, input logic [39:0] ear);
        vec_t v;
        v.arv = arv; v.mar = mar; v.mrv = mrv; v.mrl = mrl; v.srr = srr; v.rack = rack;
        v.exp = exp; v.chk_ar = chk; v.exp_ar = ear;
        tab.push_back(v);
    endtask

    task automatic run_table();
        // exp = {m_arvalid, s_arready[1:0], s_rvalid[1:0], m_rready, m_rack, busy}
        add(2'b00, 0, 0, 0, 2'b00, 2'b00, 8'b0_00_00_0_0_0, 0, 40'h0);
        add(2'b01, 0, 0, 0, 2'b00, 2'b00, 8'b0_00_00_0_0_0, 0, 40'h0);
        add(2'b11, 0, 1, 0, 2'b01, 2'b00, 8'b1_00_00_0_0_1, 1, {32'h8000_0000, 8'd0});
        add(2'b11, 1, 0, 0, 2'b00, 2'b00, 8'b1_01_00_0_0_1, 1, {32'h8000_0000, 8'd0});
        add(2'b10, 0, 1, 1, 2'b01, 2'b01, 8'b0_00_01_1_1_1, 0, 40'h0);
        add(2'b10, 0, 0, 0, 2'b00, 2'b00, 8'b0_00_00_0_0_0, 0, 40'h0);
        add(2'b10, 1, 0, 0, 2'b00, 2'b00, 8'b1_10_00_0_0_1, 1, {32'h4000_0040, 8'd3});
        add(2'b00, 0, 1, 0, 2'b10, 2'b00, 8'b0_00_10_1_0_1, 0, 40'h0);
        add(2'b00, 0, 1, 0, 2'b01, 2'b00, 8'b0_00_10_0_0_1, 0, 40'h0);
        add(2'b00, 0, 1, 0, 2'b10, 2'b00, 8'b0_00_10_1_0_1, 0, 40'h0);
        add(2'b00, 0, 0, 0, 2'b10, 2'b00, 8'b0_00_00_1_0_1, 0, 40'h0);
        add(2'b00, 0, 1, 0, 2'b10, 2'b00, 8'b0_00_10_1_0_1, 0, 40'h0);
        add(2'b00, 0, 1, 1, 2'b00, 2'b00, 8'b0_00_10_0_0_1, 0, 40'h0);
        add(2'b00, 0, 1, 1, 2'b10, 2'b10, 8'b0_00_10_1_1_1, 0, 40'h0);
        add(2'b00, 0, 1, 1, 2'b11, 2'b11, 8'b0_00_00_0_0_0, 0, 40'h0);
        add(2'b00, 0, 0, 0, 2'b00, 2'b00, 8'b0_00_00_0_0_0, 0, 40'h0);
        do_reset();
        s_araddr[0] = 32'h8000_0000; s_arlen[0] = 8'd0; s_arsize[0] = 3'd5;
        s_araddr[1] = 32'h4000_0040; s_arlen[1] = 8'd3; s_arsize[1] = 3'd5;
        for (int i = 0; i < tab.size(); i++) begin
            s_arvalid = tab[i].arv; m_arready = tab[i].mar; m_rvalid = tab[i].mrv;
            m_rlast = tab[i].mrl; s_rready = tab[i].srr; s_rack = tab[i].rack;
            #1;
            check($sformatf("tab[%0d]", i), outs(), tab[i].exp);
            if (tab[i].chk_ar) check($sformatf("tab_ar[%0d]", i), {m_araddr, m_arlen}, tab[i].exp_ar);
            tick();
        end
    endtask

    task automatic run_stall();
        do_reset();
        s_araddr[0] = 32'h1234_5678; s_arlen[0] = 8'd2; s_arsize[0] = 3'd4;
        s_araddr[1] = 32'hdead_bee0; s_arlen[1] = 8'd7; s_arsize[1] = 3'd1;
        s_arvalid = 2'b01;
        #1;
        tick();
        s_arvalid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_hold", {m_arvalid, m_araddr, m_arlen, m_arsize, s_arready},
                  {1'b1, 32'h1234_5678, 8'd2, 3'd4, 2'b00});
            tick();
        end
        m_arready = 1;
        #1;
        check("stall_hs", s_arready, 2'b01);
        tick();
    endtask

    task automatic run_contention();
        int w1, w2, w3, w4;
        w1 = (RR != 0) ? 0 : 1;
        w2 = 1 - w1;
        w3 = pick(2'b11, w2);
        w4 = pick(2'b11, 1);
        do_reset();
        s_arlen = '0;
        s_arvalid = 2'b11; m_arready = 1;
        #1;
        tick();
        check("cont_w1", s_arready, onehot(w1));
        tick();
        s_arvalid[w1] = 0;
        m_rvalid = 1; m_rlast = 1; s_rready = 2'b11;
        #1;
        check("cont_r1", s_rvalid, onehot(w1));
        tick();
        m_rvalid = 0;
        tick();
        check("cont_w2", s_arready, onehot(w2));
        tick();
        s_arvalid = 2'b00; m_rvalid = 1;
        tick();
        m_rvalid = 0; s_arvalid = 2'b11;
        tick();
        check("cont_w3", s_arready, onehot(w3));
        tick();
        s_arvalid[w3] = 0;
        m_rvalid = 1; m_rlast = 0;
        #1;
        check("rst_pre", {busy, m_rready, s_rvalid}, {1'b1, 1'b1, onehot(w3)});
        #1;
        rst = 0;
        #1;
        check("rst_async", outs(), 8'h00);
        m_rvalid = 0; s_arvalid = 2'b11;
        @(negedge clk);
        rst = 1;
        tick();
        check("rst_last", s_arready, onehot(w4));
    endtask

    task automatic run_random();
        int phase, own, lastg, beats_left, drop, ntx;
        int gr_m[2], gr_d[2], bt_m[2], bt_d[2];
        logic [1:0] e_sar, e_srv;
        logic e_mav, e_mrr, e_mrack, e_busy;
        do_reset();
        phase = 0; own = 0; lastg = 1; beats_left = 0; ntx = 0;
        gr_m = '{0, 0}; gr_d = '{0, 0}; bt_m = '{0, 0}; bt_d = '{0, 0};
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!s_arvalid[p] && $urandom_range(0, 2) == 0) begin
                    s_arvalid[p] = 1;
                    s_araddr[p] = $urandom;
                    s_arlen[p] = 8'($urandom_range(0, 3));
                    s_arsize[p] = 3'($urandom);
                end
            end
            m_arready = 1'($urandom); s_rready = 2'($urandom); s_rack = 2'($urandom);
            m_rdata = {8{$urandom}}; m_rresp = 4'($urandom);
            if (phase == 2) begin
                m_rvalid = 1'($urandom);
                m_rlast = (beats_left == 1);
            end else begin
                m_rvalid = ($urandom_range(0, 5) == 0);
                m_rlast = 1'($urandom);
            end
            #1;
            e_sar = '0; e_srv = '0; e_mav = 0; e_mrr = 0; e_mrack = 0;
            e_busy = (phase != 0);
            if (phase == 1) begin
                e_mav = s_arvalid[own];
                if (m_arready) e_sar = onehot(own);
            end else if (phase == 2) begin
                if (m_rvalid) e_srv = onehot(own);
                e_mrr = s_rready[own];
                e_mrack = s_rack[own];
            end
            check("rnd_route", outs(), {e_mav, e_sar, e_srv, e_mrr, e_mrack, e_busy});
            if (e_mav) check("rnd_ar", {m_araddr, m_arlen, m_arsize}, {s_araddr[own], s_arlen[own], s_arsize[own]});
            check("rnd_rbus", {s_rdata, s_rresp, s_rlast}, {m_rdata, m_rresp, m_rlast});
            for (int p = 0; p < 2; p++) begin
                if (s_arvalid[p] && s_arready[p]) gr_d[p]++;
                if (s_rvalid[p] && s_rready[p]) bt_d[p]++;
            end
            drop = -1;
            if (phase == 0) begin
                if (|s_arvalid) begin
                    own = pick(s_arvalid, lastg);
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (s_arvalid[own] && m_arready) begin
                    lastg = own;
                    beats_left = int'(s_arlen[own]) + 1;
                    gr_m[own]++;
                    drop = own;
                    phase = 2;
                end
            end else if (m_rvalid && s_rready[own]) begin
                bt_m[own]++;
                beats_left--;
                if (beats_left == 0) begin
                    phase = 0;
                    ntx++;
                end
            end
            tick();
            if (drop >= 0) s_arvalid[drop] = 0;
        end
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rnd_grants[%0d]", p), gr_d[p], gr_m[p]);
            check($sformatf("rnd_beats[%0d]", p), bt_d[p], bt_m[p]);
        end
        check("rnd_progress", ntx >= 100, 1'b1);
    endtask

    initial begin
        rst = 0;
        s_araddr = '0; s_arlen = '0; s_arsize = '0;
        idle_in();
        #1;
        run_table();
        run_stall();
        run_contention();
        run_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
